// File: rtl/traffic_obstacle_engine.sv
// ---------------------------------------------------------------------------
// traffic_obstacle_engine
//   Obstacle-traffic engine for the racing game. N_CARS slots fall down
//   N_LANES lanes at a level-dependent rate. The block keeps the score (cars
//   dodged) and the level. For every dtg pixel it reports which car covers
//   that pixel, as a slot index plus an in-sprite offset, so one car ROM
//   downstream serves all slots.
//
//   Optional feature macro: LFSR_LANE_EN
//     defined   -> spawn lane = LFSR[7:0] mod N_LANES (16-bit Fibonacci LFSR,
//                  taps 16,14,13,11, advancing every unpaused clock)
//     undefined -> spawn lane = round-robin pointer, +1 per spawn
//
// Ports
//   clk_i          system clock
//   reset_i        synchronous, active-high reset
//   pause_i        freezes counters, positions, spawn and retire
//   pix_row_i      current dtg row (10 bit)
//   pix_col_i      current dtg column (10 bit)
//   move_tick_o    1-cycle pulse per move step
//   level_out_o    current level 0..3
//   score_out_o    cars dodged
//   active_mask_o  bit i = slot i active
//   obj_hit_o      a car covers the pixel sampled on the previous cycle
//   obj_idx_o      slot index of the hit (lowest index wins)
//   spr_row_o      pix_row - car_y of the hit car (0 when no hit)
//   spr_col_o      pix_col - car_x of the hit car (0 when no hit)
// ---------------------------------------------------------------------------
module traffic_obstacle_engine #(
    parameter int N_CARS     = 6,
    parameter int N_LANES    = 3,
    parameter int LANE_X0    = 150,
    parameter int LANE_PITCH = 130,
    parameter int CAR_W      = 40,
    parameter int CAR_H      = 64,
    parameter int SCREEN_H   = 480,
    parameter int STEP       = 4,
    parameter int SPAWN_GAP  = 100,
    parameter int CLK_HZ     = 100000000,
    parameter int BASE_HZ    = 500,
    parameter int DIV_L0     = 8,
    parameter int DIV_L1     = 6,
    parameter int DIV_L2     = 4,
    parameter int DIV_L3     = 2,
    parameter int LVL1       = 11,
    parameter int LVL2       = 21,
    parameter int LVL3       = 36,
    parameter int SCORE_MAX  = 50,
    localparam int IW        = (N_CARS > 1) ? $clog2(N_CARS) : 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              pause_i,
    input  logic [9:0]        pix_row_i,
    input  logic [9:0]        pix_col_i,
    output logic              move_tick_o,
    output logic [1:0]        level_out_o,
    output logic [6:0]        score_out_o,
    output logic [N_CARS-1:0] active_mask_o,
    output logic              obj_hit_o,
    output logic [IW-1:0]     obj_idx_o,
    output logic [6:0]        spr_row_o,
    output logic [5:0]        spr_col_o
);

    localparam int BASE_DIV = CLK_HZ / BASE_HZ;
    localparam int BW       = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
    localparam int LW       = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam logic [BW-1:0] BASE_LAST = BW'(BASE_DIV - 1);

    function automatic logic [1:0] level_of(input logic [6:0] s);
        if (s >= 7'(LVL3)) begin
            return 2'd3;
        end else if (s >= 7'(LVL2)) begin
            return 2'd2;
        end else if (s >= 7'(LVL1)) begin
            return 2'd1;
        end else begin
            return 2'd0;
        end
    endfunction

    logic [BW-1:0]            base_cnt_q, base_cnt_d;
    logic [3:0]               div_cnt_q, div_cnt_d;
    logic [3:0]               div_lim_s;
    logic                     base_tick_s, move_s;
    logic [N_CARS-1:0]        active_q, active_d;
    logic [N_CARS-1:0][9:0]   y_q, y_d, x_q, x_d;
    logic [IW-1:0]            newest_q, newest_d;
    logic [6:0]               score_q, score_d, score_sum_s;
    logic [1:0]               level_q, level_d;
    logic                     move_tick_q;
    logic [3:0]               retire_cnt_s;
    logic                     spawn_found_s, gap_ok_s, spawn_s;
    logic [IW-1:0]            spawn_idx_s;
    logic [LW-1:0]            lane_sel_s;
    logic [9:0]               lane_x_s;
    logic                     hit_d, hit_q;
    logic [IW-1:0]            idx_d, idx_q;
    logic [6:0]               srow_d, srow_q;
    logic [5:0]               scol_d, scol_q;

    // Move divider limit follows the registered level.
    always_comb begin
        case (level_q)
            2'd0:    div_lim_s = 4'(DIV_L0);
            2'd1:    div_lim_s = 4'(DIV_L1);
            2'd2:    div_lim_s = 4'(DIV_L2);
            2'd3:    div_lim_s = 4'(DIV_L3);
            default: div_lim_s = 4'(DIV_L0);
        endcase
    end

    // '>=' only matters if the limit ever drops below a running count; it then
    // fires at once instead of running the 4-bit counter round.
    assign base_tick_s = !pause_i && (base_cnt_q == BASE_LAST);
    assign move_s      = base_tick_s && (div_cnt_q >= div_lim_s);

    // Base and divider counters; both hold while paused.
    always_comb begin
        base_cnt_d = base_cnt_q;
        div_cnt_d  = div_cnt_q;
        if (pause_i) begin
            base_cnt_d = base_cnt_q;
        end else if (base_cnt_q == BASE_LAST) begin
            base_cnt_d = '0;
            div_cnt_d  = move_s ? 4'd0 : div_cnt_q + 4'd1;
        end else begin
            base_cnt_d = base_cnt_q + BW'(1);
        end
    end

`ifdef LFSR_LANE_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16,14,13,11, free-running while not paused.
    always_comb begin
        lfsr_d = lfsr_q;
        if (!pause_i) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    assign lane_sel_s = LW'(lfsr_q[7:0] % 8'(N_LANES));

    // LFSR state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    logic [LW-1:0] lane_ptr_q, lane_ptr_d;

    // Round-robin lane pointer advances once per spawn.
    always_comb begin
        lane_ptr_d = lane_ptr_q;
        if (spawn_s) begin
            lane_ptr_d = (lane_ptr_q == LW'(N_LANES - 1)) ? '0 : lane_ptr_q + LW'(1);
        end else begin
            lane_ptr_d = lane_ptr_q;
        end
    end

    assign lane_sel_s = lane_ptr_q;

    // Lane pointer register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lane_ptr_q <= '0;
        end else begin
            lane_ptr_q <= lane_ptr_d;
        end
    end
`endif

    assign lane_x_s = 10'(LANE_X0 + LANE_PITCH * int'(lane_sel_s));

    // Spawn choice from pre-tick state: lowest inactive slot, gated by the gap
    // behind the newest car. A slot retiring this tick is still active here,
    // so it cannot be picked on the same tick.
    always_comb begin
        spawn_found_s = 1'b0;
        spawn_idx_s   = '0;
        for (int i = N_CARS - 1; i >= 0; i--) begin
            spawn_found_s = active_q[i] ? spawn_found_s : 1'b1;
            spawn_idx_s   = active_q[i] ? spawn_idx_s : IW'(i);
        end
        gap_ok_s = (active_q == '0) || (y_q[newest_q] >= 10'(SPAWN_GAP));
        spawn_s  = move_s && spawn_found_s && gap_ok_s;
    end

    // Slot movement, retirement and spawning on a move tick.
    always_comb begin
        active_d     = active_q;
        y_d          = y_q;
        x_d          = x_q;
        newest_d     = newest_q;
        retire_cnt_s = 4'd0;
        if (move_s) begin
            for (int i = 0; i < N_CARS; i++) begin
                if (!active_q[i]) begin
                    y_d[i] = y_q[i];
                end else if (y_q[i] >= 10'(SCREEN_H)) begin
                    active_d[i]  = 1'b0;
                    y_d[i]       = 10'd0;
                    retire_cnt_s = retire_cnt_s + 4'd1;
                end else begin
                    y_d[i] = y_q[i] + 10'(STEP);
                end
            end
        end else begin
            retire_cnt_s = 4'd0;
        end
        if (spawn_s) begin
            active_d[spawn_idx_s] = 1'b1;
            y_d[spawn_idx_s]      = 10'd0;
            x_d[spawn_idx_s]      = lane_x_s;
            newest_d              = spawn_idx_s;
        end else begin
            newest_d = newest_q;
        end
    end

    // Score accumulates retires; overflow past SCORE_MAX restarts score and level.
    always_comb begin
        score_sum_s = score_q + 7'(retire_cnt_s);
        if (score_sum_s > 7'(SCORE_MAX)) begin
            score_d = 7'd0;
            level_d = 2'd0;
        end else begin
            score_d = score_sum_s;
            level_d = level_of(score_q);
        end
    end

    // Pixel coverage; scanning downwards so the lowest covering index wins.
    always_comb begin
        hit_d  = 1'b0;
        idx_d  = '0;
        srow_d = 7'd0;
        scol_d = 6'd0;
        for (int i = N_CARS - 1; i >= 0; i--) begin
            if (active_q[i]
                && ({1'b0, pix_col_i} >= {1'b0, x_q[i]})
                && ({1'b0, pix_col_i} <  {1'b0, x_q[i]} + 11'(CAR_W))
                && ({1'b0, pix_row_i} >= {1'b0, y_q[i]})
                && ({1'b0, pix_row_i} <  {1'b0, y_q[i]} + 11'(CAR_H))) begin
                hit_d  = 1'b1;
                idx_d  = IW'(i);
                srow_d = 7'(pix_row_i - y_q[i]);
                scol_d = 6'(pix_col_i - x_q[i]);
            end else begin
                hit_d = hit_d;
            end
        end
    end

    // Game state registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            base_cnt_q  <= '0;
            div_cnt_q   <= 4'd0;
            active_q    <= '0;
            y_q         <= '0;
            x_q         <= '0;
            newest_q    <= '0;
            score_q     <= 7'd0;
            level_q     <= 2'd0;
            move_tick_q <= 1'b0;
        end else begin
            base_cnt_q  <= base_cnt_d;
            div_cnt_q   <= div_cnt_d;
            active_q    <= active_d;
            y_q         <= y_d;
            x_q         <= x_d;
            newest_q    <= newest_d;
            score_q     <= score_d;
            level_q     <= level_d;
            move_tick_q <= move_s;
        end
    end

    // Render result registers; they keep updating while paused.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hit_q  <= 1'b0;
            idx_q  <= '0;
            srow_q <= 7'd0;
            scol_q <= 6'd0;
        end else begin
            hit_q  <= hit_d;
            idx_q  <= idx_d;
            srow_q <= srow_d;
            scol_q <= scol_d;
        end
    end

    assign move_tick_o   = move_tick_q;
    assign level_out_o   = level_q;
    assign score_out_o   = score_q;
    assign active_mask_o = active_q;
    assign obj_hit_o     = hit_q;
    assign obj_idx_o     = idx_q;
    assign spr_row_o     = srow_q;
    assign spr_col_o     = scol_q;

endmodule
